// File: rtl/apb_io_pkg.sv
// Shared types and widths for the system I/O APB decoder slice.
package apb_io_pkg;

    localparam int APB_PAGE_W = 8;
    localparam int APB_ADDR_W = 16;
    localparam int APB_DATA_W = 8;

    typedef enum logic [1:0] {
        NONE     = 2'b00,
        UNMAPPED = 2'b01,
        TIMEOUT  = 2'b10
    } fault_cause_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } dec_state_t;

endpackage

// File: rtl/apb_io_decoder_if.sv
// APB bus bundle; N is the number of select/ready lanes (1 on the master side).
interface apb_io_decoder_if
    import apb_io_pkg::*;
#(
    parameter int N = 1
);
    logic [APB_ADDR_W-1:0]   paddr;
    logic [APB_DATA_W-1:0]   pwdata;
    logic                    pwrite;
    logic [N-1:0]            psel;
    logic                    penable;
    logic [APB_DATA_W*N-1:0] prdata;
    logic [N-1:0]            pready;

    modport master (output paddr, pwdata, pwrite, psel, penable, input prdata, pready);
    modport slave  (input paddr, pwdata, pwrite, psel, penable, output prdata, pready);
endinterface

// File: rtl/apb_io_fault_log.sv
// First-fault record with overflow flag; a new fault beats a simultaneous clear.
module apb_io_fault_log
    import apb_io_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  log_en,
    input  logic                  clr,
    input  logic [APB_ADDR_W-1:0] log_addr,
    input  logic                  log_write,
    input  fault_cause_t          log_cause,
    output logic                  valid,
    output logic                  overflow,
    output logic [APB_ADDR_W-1:0] addr,
    output logic                  write,
    output logic [1:0]            cause
);
    logic                  valid_reg;
    logic                  overflow_reg;
    logic [APB_ADDR_W-1:0] addr_reg;
    logic                  write_reg;
    fault_cause_t          cause_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            addr_reg     <= '0;
            write_reg    <= 1'b0;
            cause_reg    <= NONE;
        end else if (log_en && (clr || !valid_reg)) begin
            valid_reg    <= 1'b1;
            overflow_reg <= 1'b0;
            addr_reg     <= log_addr;
            write_reg    <= log_write;
            cause_reg    <= log_cause;
        end else if (log_en) begin
            overflow_reg <= 1'b1;
        end else if (clr) begin
            valid_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            addr_reg     <= '0;
            write_reg    <= 1'b0;
            cause_reg    <= NONE;
        end
    end

    assign valid    = valid_reg;
    assign overflow = overflow_reg;
    assign addr     = addr_reg;
    assign write    = write_reg;
    assign cause    = cause_reg;
endmodule

// File: rtl/apb_io_decoder.sv
// Page decoder between the system I/O APB master and peripheral slaves.
// Define APB_IO_DECODER_TIMEOUT_EN to terminate stuck slave accesses after TIMEOUT_CYCLES.
module apb_io_decoder
    import apb_io_pkg::*;
#(
    parameter int                    NUM_SLAVES     = 3,
    parameter int                    TIMEOUT_CYCLES = 64,
    parameter logic [APB_DATA_W-1:0] ERR_DATA       = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
    apb_io_decoder_if.slave       m_bus,
    apb_io_decoder_if.master      s_bus,
    input  logic                  fault_clr,
    output logic                  fault_int,
    output logic [APB_ADDR_W-1:0] fault_addr,
    output logic                  fault_write,
    output logic [1:0]            fault_cause,
    output logic                  fault_overflow
);
    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int SEL_N = 1 << SEL_W;
    localparam logic [APB_PAGE_W-1:0] NUM_PAGES = NUM_SLAVES[APB_PAGE_W-1:0];

    generate
        if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_param_check
            $error("apb_io_decoder: parameter out of range");
        end
    endgenerate

    dec_state_t                 state_reg, state_next;
    logic [SEL_W-1:0]           sel_idx_reg, sel_idx_next;
    logic                       unmapped_reg, unmapped_next;
    logic [APB_PAGE_W-1:0]      page;
    logic                       hit;
    logic                       access_phase;
    logic                       sel_ready;
    logic [APB_DATA_W-1:0]      sel_rdata;
    logic                       timeout_hit;
    logic                       m_pready_c;
    logic [APB_DATA_W-1:0]      m_prdata_c;
    logic                       s_penable_c;
    logic                       log_en;
    fault_cause_t               log_cause;
    logic [APB_DATA_W-1:0]      slv_rdata [SEL_N];
    logic [SEL_N-1:0]           slv_ready;

    assign page         = m_bus.paddr[APB_ADDR_W-1 -: APB_PAGE_W];
    assign hit          = m_bus.psel[0] && (page < NUM_PAGES);
    assign access_phase = (state_reg == ACCESS) && m_bus.psel[0] && m_bus.penable;

    // Lanes are padded to a power of two so the latched index selects without a range check.
    genvar gi;
    generate
        for (gi = 0; gi < SEL_N; gi++) begin : g_slv
            if (gi < NUM_SLAVES) begin : g_map
                assign slv_rdata[gi]   = s_bus.prdata[gi*APB_DATA_W +: APB_DATA_W];
                assign slv_ready[gi]   = s_bus.pready[gi];
                assign s_bus.psel[gi]  = !rst && m_bus.psel[0] && (page == 8'(gi));
            end else begin : g_pad
                assign slv_rdata[gi] = '0;
                assign slv_ready[gi] = 1'b0;
            end
        end
    endgenerate

    assign sel_ready = slv_ready[sel_idx_reg];
    assign sel_rdata = slv_rdata[sel_idx_reg];

`ifdef APB_IO_DECODER_TIMEOUT_EN
    logic [7:0] wait_cnt_reg, wait_cnt_next;

    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (state_reg == IDLE) begin
            wait_cnt_next = '0;
        end else if (access_phase && !sel_ready) begin
            wait_cnt_next = wait_cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wait_cnt_reg <= '0;
        else     wait_cnt_reg <= wait_cnt_next;
    end

    assign timeout_hit = (wait_cnt_reg == 8'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            sel_idx_reg  <= '0;
            unmapped_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sel_idx_reg  <= sel_idx_next;
            unmapped_reg <= unmapped_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        sel_idx_next  = sel_idx_reg;
        unmapped_next = unmapped_reg;
        m_pready_c    = 1'b0;
        m_prdata_c    = '0;
        s_penable_c   = 1'b0;
        log_en        = 1'b0;
        log_cause     = NONE;
        case (state_reg)
            IDLE: begin
                // An enable with no preceding setup phase is not a transfer.
                if (m_bus.psel[0] && !m_bus.penable) begin
                    state_next    = ACCESS;
                    sel_idx_next  = m_bus.paddr[APB_ADDR_W-APB_PAGE_W +: SEL_W];
                    unmapped_next = !hit;
                end
            end
            ACCESS: begin
                if (!m_bus.psel[0]) begin
                    state_next = IDLE;
                end else if (access_phase) begin
                    if (unmapped_reg) begin
                        m_pready_c = 1'b1;
                        m_prdata_c = ERR_DATA;
                        log_en     = 1'b1;
                        log_cause  = UNMAPPED;
                        state_next = IDLE;
                    end else begin
                        s_penable_c = 1'b1;
                        if (sel_ready) begin
                            m_pready_c = 1'b1;
                            m_prdata_c = sel_rdata;
                            state_next = IDLE;
                        end else if (timeout_hit) begin
                            m_pready_c = 1'b1;
                            m_prdata_c = ERR_DATA;
                            log_en     = 1'b1;
                            log_cause  = TIMEOUT;
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign s_bus.paddr    = m_bus.paddr;
    assign s_bus.pwdata   = m_bus.pwdata;
    assign s_bus.pwrite   = m_bus.pwrite;
    assign s_bus.penable  = s_penable_c;
    assign m_bus.pready   = m_pready_c;
    assign m_bus.prdata   = m_prdata_c;

    apb_io_fault_log u_fault_log (
        .clk       (clk),
        .rst       (rst),
        .log_en    (log_en),
        .clr       (fault_clr),
        .log_addr  (m_bus.paddr),
        .log_write (m_bus.pwrite),
        .log_cause (log_cause),
        .valid     (fault_int),
        .overflow  (fault_overflow),
        .addr      (fault_addr),
        .write     (fault_write),
        .cause     (fault_cause)
    );
endmodule

// File: tb/tb_apb_io_decoder.sv
// Randomized bench for apb_io_decoder against a transfer-level reference model.
module tb_apb_io_decoder;
    localparam int NS = 3;
    localparam int T  = 64;
`ifdef APB_IO_DECODER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fault_clr = 1'b0;
    logic        fault_int;
    logic [15:0] fault_addr;
    logic        fault_write;
    logic [1:0]  fault_cause;
    logic        fault_overflow;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    apb_io_decoder_if #(.N(1))  m_if ();
    apb_io_decoder_if #(.N(NS)) s_if ();

    apb_io_decoder #(.NUM_SLAVES(NS), .TIMEOUT_CYCLES(T), .ERR_DATA(8'hFF)) dut (
        .clk            (clk),
        .rst            (rst),
        .m_bus          (m_if.slave),
        .s_bus          (s_if.master),
        .fault_clr      (fault_clr),
        .fault_int      (fault_int),
        .fault_addr     (fault_addr),
        .fault_write    (fault_write),
        .fault_cause    (fault_cause),
        .fault_overflow (fault_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference fault record
    bit          mv_valid, mv_ovf, mv_write;
    logic [15:0] mv_addr;
    logic [1:0]  mv_cause;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        mv_valid = 0; mv_ovf = 0; mv_write = 0; mv_addr = '0; mv_cause = 2'b00;
    endfunction

    function automatic void model_event(bit fault, bit clr, logic [15:0] a, bit w, logic [1:0] c);
        if (fault && (clr || !mv_valid)) begin
            mv_valid = 1; mv_ovf = 0; mv_addr = a; mv_write = w; mv_cause = c;
        end else if (fault) begin
            mv_ovf = 1;
        end else if (clr) begin
            model_reset();
        end
    endfunction

    task automatic check_faults(input string tag);
        check({tag, ".fint"},  fault_int,      mv_valid);
        check({tag, ".faddr"}, fault_addr,     mv_addr);
        check({tag, ".fwr"},   fault_write,    mv_write);
        check({tag, ".fcause"},fault_cause,    mv_cause);
        check({tag, ".fovf"},  fault_overflow, mv_ovf);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            m_if.psel = 1'b0; m_if.penable = 1'b0; fault_clr = 1'b0; s_if.pready = '0;
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        m_if.psel = 1'b0; m_if.penable = 1'b0; fault_clr = 1'b1;
        model_event(0, 1, 16'h0, 0, 2'b00);
        @(negedge clk);
        fault_clr = 1'b0;
    endtask

    // One APB transfer; the slave addressed answers ready in access cycle delay+1.
    task automatic xfer(input logic [15:0] addr, input bit wr, input logic [7:0] wd,
                        input int delay, input logic [23:0] rd, input bit clr_at_done,
                        input int limit, input string tag, output int t_setup, output int t_done);
        int          page;
        bit          mapped;
        int          exp_cyc, got_cyc, n;
        logic [7:0]  exp_data, got_data;
        bit          fault;
        logic [1:0]  cause;
        logic [2:0]  pr;
        page   = int'(addr[15:8]);
        mapped = page < NS;
        fault  = 0; cause = 2'b00; exp_data = 8'h00;
        if (!mapped) begin
            exp_cyc = 1; exp_data = 8'hFF; fault = 1; cause = 2'b01;
        end else if (TO_EN && delay >= T) begin
            exp_cyc = T; exp_data = 8'hFF; fault = 1; cause = 2'b10;
        end else if (delay + 1 > limit) begin
            exp_cyc = 0;
        end else begin
            exp_cyc = delay + 1; exp_data = rd[page*8 +: 8];
        end

        @(negedge clk);
        check_faults({tag, ".pre"});
        fault_clr = 1'b0;
        m_if.psel = 1'b1; m_if.penable = 1'b0; m_if.paddr = addr;
        m_if.pwrite = wr; m_if.pwdata = wd;
        s_if.prdata = rd; s_if.pready = '0;
        t_setup = cyc;
        #1;
        check({tag, ".psel"}, s_if.psel, mapped ? (32'd1 << page) : 32'd0);
        check({tag, ".setup_rdy"}, m_if.pready, 1'b0);

        n = 0; got_cyc = 0; got_data = 8'h00; t_done = 0;
        while (n < limit && got_cyc == 0) begin
            @(negedge clk);
            m_if.penable = 1'b1;
            n++;
            pr = 3'($urandom_range(0, 7));
            if (mapped) pr[page] = (n > delay);
            s_if.pready = pr;
            #1;
            if (n == 1) check({tag, ".s_pen"}, s_if.penable, mapped);
            if (m_if.pready) begin
                got_cyc = n; got_data = m_if.prdata; t_done = cyc;
                if (clr_at_done) fault_clr = 1'b1;
            end else if (m_if.prdata !== 8'h00) begin
                check({tag, ".wait_rd"}, m_if.prdata, 8'h00);
            end
        end
        check({tag, ".cyc"}, got_cyc, exp_cyc);
        if (exp_cyc != 0) begin
            check({tag, ".data"}, got_data, exp_data);
            model_event(fault, clr_at_done, addr, wr, cause);
        end
        if (got_cyc == 0) begin
            @(negedge clk);
            m_if.psel = 1'b0; m_if.penable = 1'b0; s_if.pready = '0;
        end
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int ts, td, t0, t1;
        logic [15:0] a;
        int r, pg, dly;
        model_reset();
        m_if.psel = 0; m_if.penable = 0; m_if.paddr = '0; m_if.pwrite = 0; m_if.pwdata = '0;
        s_if.prdata = '0; s_if.pready = '0;
        repeat (3) @(negedge clk);
        check("rst.pready", m_if.pready, 1'b0);
        check("rst.prdata", m_if.prdata, 8'h00);
        check("rst.spsel",  s_if.psel, 3'b000);
        check("rst.spen",   s_if.penable, 1'b0);
        check_faults("rst");
        rst = 1'b0;
        idle(2);

        // Slave 1 answers 5A after three wait cycles
        xfer(16'h0110, 0, 8'h00, 3, 24'h115A22, 0, 300, "rd_p1", ts, td);
        // Unmapped write
        xfer(16'h0703, 1, 8'h3C, 0, 24'h0, 0, 300, "wr_unmap", ts, td);
        idle(1);
        check_faults("unmap");
        check("unmap.addr", fault_addr, 16'h0703);
        check("unmap.cause", fault_cause, 2'b01);

        // Stuck slave on page 2: timeout when enabled, otherwise a stalled bus
        xfer(16'h0240, 0, 8'h00, 1000, $urandom, 0, 200, "stuck", ts, td);
        if (!TO_EN) xfer(16'h0912, 0, 8'h00, 0, 24'h0, 0, 300, "unmap2", ts, td);
        xfer(16'h0A55, 0, 8'h00, 0, 24'h0, 1, 300, "clr_set", ts, td);
        idle(1);
        check_faults("clr_set");
        check("clr_set.addr", fault_addr, 16'h0A55);
        check("clr_set.ovf", fault_overflow, 1'b0);
        check("clr_set.int", fault_int, 1'b1);

        // Enable without setup is ignored
        @(negedge clk);
        m_if.psel = 1; m_if.penable = 1; m_if.paddr = 16'h0000; s_if.pready = 3'b111;
        repeat (2) begin
            #1;
            check("nosetup.rdy", m_if.pready, 1'b0);
            check("nosetup.spen", s_if.penable, 1'b0);
            @(negedge clk);
        end
        idle(1);

        // Back-to-back reads 0,1,0
        xfer(16'h0001, 0, 8'h00, 0, 24'hC3B2A1, 0, 300, "b2b0", t0, td);
        xfer(16'h0102, 0, 8'h00, 0, 24'h44D5E6, 0, 300, "b2b1", ts, td);
        xfer(16'h0003, 0, 8'h00, 0, 24'h778899, 0, 300, "b2b2", ts, t1);
        check("b2b.span", t1 - t0 + 1, 6);
        idle(1);

        // Asynchronous reset mid-access on page 0 with a fault on record
        check_faults("prerst");
        @(negedge clk);
        m_if.psel = 1; m_if.penable = 0; m_if.paddr = 16'h0010; s_if.pready = '0;
        @(negedge clk);
        m_if.penable = 1;
        #1;
        check("prerst.spen", s_if.penable, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check("midrst.pready", m_if.pready, 1'b0);
        check("midrst.prdata", m_if.prdata, 8'h00);
        check("midrst.spsel",  s_if.psel, 3'b000);
        check("midrst.spen",   s_if.penable, 1'b0);
        check_faults("midrst");
        idle(1);
        rst = 1'b0;
        idle(1);
        xfer(16'h0020, 0, 8'h00, 1, 24'h00009D, 0, 300, "postrst", ts, td);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            r  = $urandom_range(0, 9);
            pg = (r < 7) ? (r % NS) : $urandom_range(NS, 255);
            dly = $urandom_range(0, 4);
            if (TO_EN && $urandom_range(0, 9) == 0) dly = 70;
            a = {8'(pg), 8'($urandom)};
            xfer(a, 1'($urandom), 8'($urandom), dly, 24'($urandom), ($urandom_range(0, 5) == 0),
                 300, $sformatf("rnd%0d", i), ts, td);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
            if ($urandom_range(0, 7) == 0) pulse_clr();
        end
        idle(2);
        check_faults("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/apb_io_decoder.md
Name: apb_io_decoder

Overview:
- Sits between the system I/O APB master port and the peripheral APB slaves (UART, GPIO banks).
- Decodes the 256-byte page in paddr[15:8] to one slave select and forwards setup/access phases.
- Muxes slave read data and ready back to the master.
- Terminates transfers to unmapped pages and stuck slaves, latches the first fault and raises an interrupt.

Parameters:
- NUM_SLAVES, 3, number of slave ports; slave k owns page k (paddr[15:8]==k), 1..16.
- TIMEOUT_CYCLES, 64, access-phase wait cycles before forced completion, 2..255.
- ERR_DATA, 8'hFF, read data returned on unmapped or timed-out transfers.

Ports:
- clk  in  1  system I/O clock
- rst  in  1  asynchronous reset, active-high
- m_paddr  in  16  master address
- m_pwdata  in  8  master write data
- m_pwrite  in  1  master write strobe
- m_psel  in  1  master select
- m_penable  in  1  master enable
- m_prdata  out  8  read data to master
- m_pready  out  1  ready to master
- s_paddr  out  16  address to slaves (m_paddr passthrough)
- s_pwdata  out  8  write data to slaves (passthrough)
- s_pwrite  out  1  passthrough
- s_penable  out  1  m_penable gated by "selected slave valid"
- s_psel  out  NUM_SLAVES  one-hot slave select
- s_prdata  in  8*NUM_SLAVES  slave k data at [8k+7:8k]
- s_pready  in  NUM_SLAVES  slave readies
- fault_clr  in  1  single-cycle clear of the fault record
- fault_int  out  1  level interrupt, = fault_valid
- fault_addr  out  16  address of the first faulting transfer
- fault_write  out  1  the first fault was a write
- fault_cause  out  2  01 unmapped, 10 timeout
- fault_overflow  out  1  a further fault occurred while fault_valid

Behaviour:
- Reset (async): FSM IDLE, wait_cnt 0, all fault outputs 0, s_psel 0, s_penable 0, m_pready 0, m_prdata 0.
- Decode (combinational, no added latency):
  - hit = m_psel & (m_paddr[15:8] < NUM_SLAVES).
  - s_psel[k] = m_psel & (m_paddr[15:8]==k).
- FSM IDLE:
  - m_psel & !m_penable -> ACCESS; latch sel_idx and unmapped = !hit; wait_cnt <= 0.
  - m_penable without a preceding setup phase: ignored; stays in IDLE, m_pready 0, s_penable 0.
- FSM ACCESS (m_psel & m_penable):
  - Unmapped: m_pready=1 and m_prdata=ERR_DATA in the first access cycle; log fault cause 01; -> IDLE.
  - Mapped, s_pready[sel_idx]=1: m_pready=1, m_prdata=s_prdata[sel_idx]; -> IDLE.
  - Otherwise wait_cnt++.
  - wait_cnt==TIMEOUT_CYCLES-1 with no ready: m_pready=1, m_prdata=ERR_DATA; log cause 10; -> IDLE. The slave sees its transfer abandoned.
  - Master drops m_psel in ACCESS (protocol abort): -> IDLE, no fault.
- Back-to-back transfers: the setup phase of the next transfer arrives the cycle after completion and is handled from IDLE; no dead cycles are inserted.
- m_prdata is 0 whenever m_pready is 0.
- Fault record:
  - On a logged fault with fault_valid=0: capture m_paddr, m_pwrite and cause; fault_valid<=1.
  - On a logged fault with fault_valid=1: fault_overflow<=1; the record is kept.
  - fault_clr clears valid, overflow, addr, write and cause.
  - fault_clr in the same cycle as a new fault: the new fault is captured (set wins) and overflow is cleared.
- The FSM is a registered state; every m_pready path is combinational from state and inputs.

Optional Feature:
- Macro APB_IO_DECODER_TIMEOUT_EN.
- Defined: the wait counter and timeout termination operate as described above.
- Undefined: no counter is instantiated; a mapped access waits indefinitely for s_pready; cause 10 never occurs. Unmapped termination and fault capture remain.

Decomposition:
- Package apb_io_pkg:
  - fault_cause_t enum (NONE=2'b00, UNMAPPED=2'b01, TIMEOUT=2'b10).
  - APB_PAGE_W=8, APB_ADDR_W=16, APB_DATA_W=8.
  - dec_state_t enum (IDLE, ACCESS).
- Sub-module apb_io_fault_log: capture/overflow/clear register with set-wins priority. Decode and FSM stay in the top.

Test Plan:
- Read page 1, slave 1 ready after 3 wait cycles with data 8'h5A -> s_psel=3'b010; m_pready high exactly in the 4th access cycle with m_prdata=8'h5A; fault_int stays 0.
- Write to 16'h0703 (unmapped, NUM_SLAVES=3) -> m_pready in the first access cycle with ERR_DATA; s_psel=0; fault_addr=16'h0703, fault_write=1, cause=01, fault_int=1.
- Read page 2 with s_pready held 0, TIMEOUT_CYCLES=64 -> forced m_pready on access cycle 64 with 8'hFF; cause=10. With the macro undefined, the bus stays stalled after 200 cycles and no fault is logged.
- Unmapped fault, then a timeout fault, then fault_clr pulsed in the same cycle as a third, unmapped fault -> record holds the third fault's address, overflow=0, fault_int=1.
- Back-to-back reads of pages 0, 1, 0 with immediate readiness -> three completions in 6 cycles with the correct data per slave.
- rst asserted mid-access on page 0 -> all outputs 0 asynchronously; after release the next transfer completes normally.
